// File: rtl/const_div_pkg.sv
// Shared constants, helper functions and the FSM state type for the constant
// divider. The optional signed mode is selected with CONST_DIV_SIGNED_EN.
package const_div_pkg;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  // Bits needed to hold any remainder 0..divisor-1.
  function automatic int rem_width(input int divisor);
    return clog2(divisor);
  endfunction

  // Remainder width as presented on the output port (one extra sign bit in
  // signed mode).
  function automatic int out_rem_width(input int divisor);
`ifdef CONST_DIV_SIGNED_EN
    return clog2(divisor) + 1;
`else
    return clog2(divisor);
`endif
  endfunction

  // Number of chunk steps needed to consume the whole dividend.
  function automatic int num_steps(input int width, input int chunk);
    return (width + chunk - 1) / chunk;
  endfunction

  // Dividend width rounded up to a whole number of chunks.
  function automatic int pad_width(input int width, input int chunk);
    return num_steps(width, chunk) * chunk;
  endfunction

  // Step counter width; never narrower than one bit.
  function automatic int cnt_width(input int nsteps);
    return (nsteps > 1) ? clog2(nsteps) : 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/const_div_seq_if.sv
// Handshake bundle for the constant divider: dividend in, quotient/remainder
// out. The out_rem width grows by one sign bit when CONST_DIV_SIGNED_EN is set.
interface const_div_seq_if #(
  parameter int WIDTH   = 32,
  parameter int DIVISOR = 11
);
  import const_div_pkg::*;

  localparam int ORW = out_rem_width(DIVISOR);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_dividend;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_quot;
  logic [ORW-1:0]   out_rem;
  logic             busy;

  // Producer/consumer side that drives dividends and accepts results.
  modport master (
    output in_valid,
    output in_dividend,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_quot,
    input  out_rem,
    input  busy
  );

  // Divider side.
  modport slave (
    input  in_valid,
    input  in_dividend,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_quot,
    output out_rem,
    output busy
  );

endinterface

// File: rtl/const_div_step.sv
// One radix-2^CHUNK long-division step against a constant divisor. Because the
// divisor is fixed, the step is a lookup table indexed by {rem_in, bits_in};
// no division hardware is generated.
module const_div_step
  import const_div_pkg::*;
#(
  parameter int DIVISOR = 11,
  parameter int CHUNK   = 3,
  localparam int RW     = rem_width(DIVISOR)
) (
  input  logic [RW-1:0]    rem_in,
  input  logic [CHUNK-1:0] bits_in,
  output logic [CHUNK-1:0] digit,
  output logic [RW-1:0]    rem_out
);

  localparam int TW      = RW + CHUNK;
  localparam int ENTRIES = 1 << TW;

  logic [TW-1:0]    index;
  logic [CHUNK-1:0] rom_digit [ENTRIES];
  logic [RW-1:0]    rom_rem   [ENTRIES];

  assign index = {rem_in, bits_in};

  // Table contents are elaboration-time constants. Entries with
  // rem_in >= DIVISOR are unreachable, so their truncated digits never matter;
  // for reachable entries rem_in < DIVISOR keeps the quotient below 2^CHUNK.
  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_rom
    localparam int QV = gi / DIVISOR;
    localparam int RV = gi % DIVISOR;
    assign rom_digit[gi] = CHUNK'(QV);
    assign rom_rem[gi]   = RW'(RV);
  end

  // Table lookup for the current step.
  always_comb begin
    digit   = rom_digit[index];
    rem_out = rom_rem[index];
  end

endmodule

// File: rtl/const_div_seq.sv
// Sequential divider by a compile-time constant. Retires CHUNK dividend bits
// per cycle, MSB first, using const_div_step. Define CONST_DIV_SIGNED_EN for
// two's-complement operands (truncating division, remainder takes the
// dividend's sign); otherwise operation is unsigned.
module const_div_seq
  import const_div_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DIVISOR = 11,
  parameter int CHUNK   = 3
) (
  input  logic           clk,
  input  logic           rst,
  const_div_seq_if.slave bus
);

  localparam int RW     = rem_width(DIVISOR);
  localparam int ORW    = out_rem_width(DIVISOR);
  localparam int NSTEPS = num_steps(WIDTH, CHUNK);
  localparam int PW     = pad_width(WIDTH, CHUNK);
  localparam int CW     = cnt_width(NSTEPS);

  state_t           state_reg;
  state_t           state_next;
  logic             accept;
  logic             step_en;
  logic             last_step;

  logic [PW-1:0]    shift_reg;
  logic [PW-1:0]    shift_next;
  logic [RW-1:0]    rem_reg;
  logic [RW-1:0]    rem_step;
  logic [WIDTH-1:0] quot_reg;
  logic [WIDTH-1:0] quot_next;
  logic [CW-1:0]    cnt_reg;
  logic [CHUNK-1:0] digit;
  logic [WIDTH-1:0] magnitude;

  assign last_step = (cnt_reg == CW'(NSTEPS - 1));

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_next    = state_reg;
    accept        = 1'b0;
    step_en       = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (state_reg)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          accept     = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        bus.busy = 1'b1;
        step_en  = 1'b1;
        if (last_step) begin
          state_next = DONE;
        end
      end
      DONE: begin
        // No overlap: a new dividend is only taken once back in IDLE.
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  const_div_step #(
    .DIVISOR (DIVISOR),
    .CHUNK   (CHUNK)
  ) u_step (
    .rem_in  (rem_reg),
    .bits_in (shift_reg[PW-1 -: CHUNK]),
    .digit   (digit),
    .rem_out (rem_step)
  );

  // Shift the consumed chunk out of the dividend register.
  if (NSTEPS > 1) begin : g_shift_multi
    assign shift_next = {shift_reg[PW-CHUNK-1:0], {CHUNK{1'b0}}};
  end else begin : g_shift_single
    assign shift_next = '0;
  end

  // Shift the new digit into the quotient LSBs. Quotient bits above WIDTH
  // would always be zero (the dividend is below 2^WIDTH), so they are not kept.
  if (WIDTH > CHUNK) begin : g_quot_wide
    assign quot_next = {quot_reg[WIDTH-CHUNK-1:0], digit};
  end else begin : g_quot_narrow
    assign quot_next = digit[WIDTH-1:0];
  end

`ifdef CONST_DIV_SIGNED_EN
  logic           dividend_sign;
  logic           sign_reg;
  logic [ORW-1:0] rem_out_reg;

  // The most negative input negates to itself, which read as unsigned is
  // exactly 2^(WIDTH-1), the correct magnitude.
  assign dividend_sign = bus.in_dividend[WIDTH-1];
  assign magnitude     = dividend_sign ? -bus.in_dividend : bus.in_dividend;

  // Sign capture and signed remainder; the sign fix-up happens on the last
  // step edge so latency matches the unsigned build.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_reg    <= 1'b0;
      rem_out_reg <= '0;
    end else if (accept) begin
      sign_reg    <= dividend_sign;
      rem_out_reg <= '0;
    end else if (step_en && last_step) begin
      rem_out_reg <= sign_reg ? -{1'b0, rem_step} : {1'b0, rem_step};
    end
  end

  assign bus.out_rem = rem_out_reg;
`else
  assign magnitude   = bus.in_dividend;
  assign bus.out_rem = rem_reg;
`endif

  assign bus.out_quot = quot_reg;

  // Datapath: load on accept, one chunk per BUSY cycle, hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      rem_reg   <= '0;
      quot_reg  <= '0;
      cnt_reg   <= '0;
    end else if (accept) begin
      shift_reg <= PW'(magnitude);
      rem_reg   <= '0;
      quot_reg  <= '0;
      cnt_reg   <= '0;
    end else if (step_en) begin
      shift_reg <= shift_next;
      rem_reg   <= rem_step;
      cnt_reg   <= cnt_reg + CW'(1);
`ifdef CONST_DIV_SIGNED_EN
      quot_reg  <= (last_step && sign_reg) ? -quot_next : quot_next;
`else
      quot_reg  <= quot_next;
`endif
    end
  end

endmodule

// File: tb/tb_const_div_seq.sv
// Self-checking bench for const_div_seq at default parameters. Expected
// results come from plain integer division in a reference model.
module tb_const_div_seq;

  localparam int WIDTH   = 32;
  localparam int DIVISOR = 11;
  localparam int CHUNK   = 3;
  localparam int NSTEPS  = (WIDTH + CHUNK - 1) / CHUNK;
`ifdef CONST_DIV_SIGNED_EN
  localparam int ORW = $clog2(DIVISOR) + 1;
`else
  localparam int ORW = $clog2(DIVISOR);
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_vec = 0;
  int n_err = 0;
  int n_txn = 0;

  // Results recorded by the driver task for the calling test to check.
  logic [WIDTH-1:0] res_q;
  logic [ORW-1:0]   res_r;
  int               res_lat;
  bit               res_tmo;
  bit               res_ir_bad;
  bit               res_busy_bad;
  bit               res_stable_bad;
  bit               res_rel_bad;

  const_div_seq_if #(.WIDTH(WIDTH), .DIVISOR(DIVISOR)) bus ();

  const_div_seq #(
    .WIDTH   (WIDTH),
    .DIVISOR (DIVISOR),
    .CHUNK   (CHUNK)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Reference model: integer division semantics.
  function automatic void ref_div(input logic [WIDTH-1:0] a,
                                  output logic [WIDTH-1:0] q,
                                  output logic [ORW-1:0] r);
`ifdef CONST_DIV_SIGNED_EN
    longint sa, sq, sr;
    sa = longint'(signed'(a));
    sq = sa / DIVISOR;
    sr = sa % DIVISOR;
    q  = WIDTH'(sq);
    r  = ORW'(sr);
`else
    longint unsigned ua;
    ua = {32'd0, a};
    q  = WIDTH'(ua / DIVISOR);
    r  = ORW'(ua % DIVISOR);
`endif
  endfunction

  // Drive one dividend through the handshake, hold out_ready low for `hold`
  // cycles in DONE, then release. Records observations only.
  task automatic do_div(input logic [WIDTH-1:0] a, input int hold);
    int w;
    res_tmo = 0; res_ir_bad = 0; res_busy_bad = 0;
    res_stable_bad = 0; res_rel_bad = 0; res_lat = 0;
    res_q = '0; res_r = '0;
    @(negedge clk);
    w = 0;
    while (bus.in_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (bus.in_ready !== 1'b1) begin
      res_tmo = 1;
      return;
    end
    bus.in_valid    = 1'b1;
    bus.in_dividend = a;
    @(posedge clk); #1;
    // Garbage on the inputs while busy must be ignored.
    bus.in_dividend = WIDTH'($urandom);
    while (bus.out_valid !== 1'b1 && res_lat < 4 * NSTEPS + 8) begin
      if (bus.in_ready !== 1'b0) res_ir_bad = 1;
      if (bus.busy !== 1'b1) res_busy_bad = 1;
      bus.in_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      res_lat++;
    end
    bus.in_valid = 1'b0;
    if (bus.out_valid !== 1'b1) begin
      res_tmo = 1;
      return;
    end
    res_q = bus.out_quot;
    res_r = bus.out_rem;
    repeat (hold) begin
      if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0) res_ir_bad = 1;
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b1 || bus.out_quot !== res_q || bus.out_rem !== res_r)
        res_stable_bad = 1;
    end
    if (bus.in_ready !== 1'b0) res_ir_bad = 1;
    // Offer a new dividend together with out_ready: it must not be taken.
    bus.out_ready   = 1'b1;
    bus.in_valid    = 1'b1;
    bus.in_dividend = WIDTH'($urandom);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) res_rel_bad = 1;
    n_txn++;
    $display("txn %0d: dividend=0x%08h quot=0x%08h rem=0x%0h lat=%0d hold=%0d",
             n_txn, a, res_q, res_r, res_lat, hold);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100) begin
      n_err++;
      $display("FAIL reset_flags: got rdy/vld/busy=%b required 100",
               {bus.in_ready, bus.out_valid, bus.busy});
    end
    n_vec++;
    if (bus.out_quot !== '0 || bus.out_rem !== '0) begin
      n_err++;
      $display("FAIL reset_data: got quot=%0h rem=%0h required 0/0", bus.out_quot, bus.out_rem);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: got in_ready=%b busy=%b required 1/0", bus.in_ready, bus.busy);
    end
  endtask

  // Checks common to every recorded transaction against given expectations.
  task automatic test_result(input string name, input logic [WIDTH-1:0] eq,
                             input logic [ORW-1:0] er);
    n_vec++;
    if (res_tmo) begin
      n_err++;
      $display("FAIL %s_timeout: got no handshake completion, required completion", name);
      return;
    end
    n_vec++;
    if (res_q !== eq) begin
      n_err++;
      $display("FAIL %s_quot: got %0d required %0d", name, res_q, eq);
    end
    n_vec++;
    if (res_r !== er) begin
      n_err++;
      $display("FAIL %s_rem: got 0x%0h required 0x%0h", name, res_r, er);
    end
    n_vec++;
    if (res_lat !== NSTEPS) begin
      n_err++;
      $display("FAIL %s_latency: got %0d required %0d", name, res_lat, NSTEPS);
    end
    n_vec++;
    if (res_ir_bad || res_busy_bad || res_rel_bad) begin
      n_err++;
      $display("FAIL %s_handshake: got ir_bad=%0b busy_bad=%0b rel_bad=%0b required 0/0/0",
               name, res_ir_bad, res_busy_bad, res_rel_bad);
    end
  endtask

  task automatic test_basic();
    do_div(32'd100, 0);
    test_result("basic_100", 32'd9, ORW'(1));
  endtask

  task automatic test_edges();
    do_div(32'hFFFF_FFFF, 0);
`ifdef CONST_DIV_SIGNED_EN
    test_result("edge_all_ones", 32'd0, ORW'(-1));
`else
    test_result("edge_all_ones", 32'd390451572, ORW'(3));
`endif
    do_div(32'd10, 1);
    test_result("edge_below_divisor", 32'd0, ORW'(10));
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] eq;
    logic [ORW-1:0]   er;
    ref_div(32'd777777, eq, er);
    do_div(32'd777777, 5);
    test_result("backpressure", eq, er);
    n_vec++;
    if (res_stable_bad) begin
      n_err++;
      $display("FAIL backpressure_stable: got outputs changing, required stable");
    end
  endtask

  task automatic test_reset_mid();
    int w;
    @(negedge clk);
    w = 0;
    while (bus.in_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    bus.in_valid    = 1'b1;
    bus.in_dividend = 32'd12345;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    n_vec++;
    if (bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL midreset_busy: got busy=%b required 1", bus.busy);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100 ||
        bus.out_quot !== '0 || bus.out_rem !== '0) begin
      n_err++;
      $display("FAIL midreset_async: got rdy/vld/busy=%b quot=%0h rem=%0h required 100/0/0",
               {bus.in_ready, bus.out_valid, bus.busy}, bus.out_quot, bus.out_rem);
    end
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
    do_div(32'd22, 0);
    test_result("after_reset_22", 32'd2, ORW'(0));
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] eq;
    logic [ORW-1:0]   er;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 7))
        0:       a = '0;
        1:       a = 32'hFFFF_FFFF;
        2:       a = 32'h8000_0000;
        3:       a = WIDTH'($urandom_range(0, 200));
        default: a = WIDTH'($urandom);
      endcase
      repeat ($urandom_range(0, 3)) @(negedge clk);
      ref_div(a, eq, er);
      do_div(a, int'($urandom_range(0, 3)));
      test_result("random", eq, er);
      n_vec++;
      if (res_stable_bad) begin
        n_err++;
        $display("FAIL random_stable: got outputs changing, required stable");
      end
    end
  endtask

`ifdef CONST_DIV_SIGNED_EN
  task automatic test_signed();
    do_div(-32'sd100, 0);
    test_result("signed_m100", WIDTH'(-9), ORW'(-1));
    do_div(32'h8000_0000, 2);
    test_result("signed_min", WIDTH'(-195225786), ORW'(-2));
  endtask
`endif

  initial begin
    bus.in_valid    = 1'b0;
    bus.in_dividend = '0;
    bus.out_ready   = 1'b0;
    test_reset();
    test_basic();
    test_edges();
    test_backpressure();
    test_reset_mid();
`ifdef CONST_DIV_SIGNED_EN
    test_signed();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/const_div_seq.md
Name: const_div_seq

Overview:
Sequential divider of a WIDTH-bit dividend by a compile-time constant DIVISOR. It produces the quotient and remainder.
- Each cycle it retires CHUNK dividend bits, MSB-first, through a combinational digit/remainder step.
- It is the parametrised successor to the fixed divide-by-11 chunk lookups: it generalises width, divisor and radix, and adds a valid/ready handshake.
- It sits in the datapath wherever a constant division result is needed.

Parameters:
WIDTH, 32, dividend and quotient width in bits (>= 2).
DIVISOR, 11, constant divisor (>= 2; a power of two is legal but gives no benefit).
CHUNK, 3, dividend bits consumed per cycle (1..8).
Derived, in the package:
- RW = clog2(DIVISOR), remainder width.
- NSTEPS = ceil(WIDTH/CHUNK).
- PW = NSTEPS*CHUNK, padded width.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  dividend valid
in_ready  out  1  block can accept a dividend
in_dividend  in  WIDTH  dividend
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_quot  out  WIDTH  quotient
out_rem  out  RW  remainder
busy  out  1  high in BUSY state

Behaviour:
- FSM states:
  - IDLE -> BUSY on in_valid && in_ready.
  - BUSY -> DONE when the step counter reaches NSTEPS-1 and its step executes.
  - DONE -> IDLE on out_valid && out_ready.
- in_ready = (state==IDLE). out_valid = (state==DONE). busy = (state==BUSY).
- Accept: at the accepting edge, load the shift register with the dividend zero-extended to PW bits, clear the remainder register to 0, clear the step counter to 0.
- Step, each BUSY edge:
  - t = {rem, top CHUNK bits of shift register}, width RW+CHUNK.
  - digit = t / DIVISOR, rem = t % DIVISOR.
  - Shift the register left by CHUNK and shift the digit into the quotient register LSBs.
  - Increment the counter.
  - The invariant rem < DIVISOR guarantees digit < 2^CHUNK.
- Latency: accept at edge E0; out_valid is high after edge E0+NSTEPS (11 cycles at defaults).
- out_quot = low WIDTH bits of the quotient register. The discarded padding bits are always 0.
- Throughput: one result per NSTEPS+2 cycles at most. No overlap: in_ready stays low in DONE even when out_ready is high.
- Backpressure: in DONE with out_ready low, out_valid, out_quot and out_rem hold stable indefinitely.
- Input behaviour outside IDLE:
  - in_dividend is ignored outside IDLE.
  - in_valid may toggle freely without effect.
- Reset, async, any state including mid-operation: state=IDLE, all datapath registers 0, out_valid=0, out_quot=0, out_rem=0, busy=0, in_ready=1 after release. A partial result is discarded and never presented.
- DIVISOR and CHUNK are constants, so the step synthesises to a small ROM/LUT with RW+CHUNK inputs. No runtime division hardware.

Optional Feature:
Macro CONST_DIV_SIGNED_EN.
- Defined:
  - in_dividend is two's complement.
  - On accept, the block stores the sign and the magnitude |dividend|; the most negative value maps to the unsigned 2^(WIDTH-1).
  - At the DONE transition, quotient and remainder are negated when the sign is set. Division truncates toward zero and the remainder takes the dividend's sign.
  - out_rem becomes RW+1 bits, signed.
  - Latency is unchanged; the negation is folded into the last-step edge.
- Undefined: unsigned operation only; out_rem is RW bits.

Decomposition:
- Package const_div_pkg holds:
  - clog2 function;
  - derived constants RW, NSTEPS, PW, computed by functions of the parameters;
  - state enum typedef {IDLE, BUSY, DONE};
  - counter width clog2(NSTEPS).
- Sub-module const_div_step: combinational, parameters DIVISOR and CHUNK. Inputs: rem_in[RW], bits_in[CHUNK]. Outputs: digit[CHUNK], rem_out[RW]. It is instantiated once in the top.

Test Plan:
- Reset then in_dividend=100 -> after 11 cycles out_quot=9, out_rem=1; in_ready low throughout BUSY/DONE.
- in_dividend=0xFFFFFFFF -> out_quot=390451572, out_rem=3; in_dividend=10 -> out_quot=0, out_rem=10.
- Hold out_ready low for 5 cycles in DONE -> outputs stable and in_ready=0; pulse out_ready -> IDLE next cycle, in_ready=1.
- Assert rst at step 5 of dividend 12345 -> all outputs 0 immediately. Afterwards 22 -> out_quot=2, out_rem=0, with no stale data.
- Random sweep of 10k dividends with DIVISOR in {3, 7, 11, 13} and CHUNK in {1, 2, 3, 4}, with random valid/ready gaps -> match a reference model, latency exactly NSTEPS.
- With CONST_DIV_SIGNED_EN: -100 -> out_quot=-9, out_rem=-1; 0x80000000 -> out_quot=-195225786, out_rem=-2.
